// File: rtl/uf_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uf_pkg : opcodes, FSM states and latency select for uf_exec_unit |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package uf_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0101;

  localparam int c_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Illegal opcodes still retire, after a single cycle
  function automatic logic [c_CNT_W-1:0] lat_of(input logic [3:0] op, input int lat_add,
                                                input int lat_mul, input int lat_div);
    case (op)
      OP_ADD, OP_SUB: lat_of = c_CNT_W'(lat_add);
      OP_MUL:         lat_of = c_CNT_W'(lat_mul);
      OP_DIV:         lat_of = c_CNT_W'(lat_div);
      default:        lat_of = c_CNT_W'(1);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uf_alu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uf_alu : combinational ADD/SUB/MUL/DIV with error flag            |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module uf_alu
  import uf_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic [WIDTH-1:0] data,
  output logic             err
);

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (op)
      OP_ADD: data = src2 + src1;
      OP_SUB: data = src2 - src1;
      OP_MUL: data = src2 * src1;
      OP_DIV: begin
        if (src1 == '0) begin
          data = '1;
          err  = 1'b1;
        end else begin
          data = src2 / src1;
        end
      end
      default: err = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/uf_exec_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uf_exec_unit : Tomasulo FU with per-class latency and CDB holding |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module uf_exec_unit
  import uf_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TAG_W   = 3,
  parameter int LAT_ADD = 1,
  parameter int LAT_MUL = 2,
  parameter int LAT_DIV = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       issue_op,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [WIDTH-1:0] issue_src1,
  input  logic [WIDTH-1:0] issue_src2,
  input  logic             flush,
  input  logic             cdb_grant,
  output logic             cdb_valid,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [WIDTH-1:0] cdb_data,
  output logic             cdb_err,
  output logic             busy
);

  state_t               r_state;
  state_t               w_next;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [3:0]           r_op;
  logic [TAG_W-1:0]     r_tag;
  logic [WIDTH-1:0]     r_src1;
  logic [WIDTH-1:0]     r_src2;
  logic [WIDTH-1:0]     w_alu_data;
  logic                 w_alu_err;
  logic                 w_fire;
  logic                 w_finish;

  uf_alu #(.WIDTH(WIDTH)) u_alu (
    .op   (r_op),
    .src1 (r_src1),
    .src2 (r_src2),
    .data (w_alu_data),
    .err  (w_alu_err)
  );

  assign issue_ready = ~flush & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & cdb_grant));
  assign w_fire      = issue_valid & issue_ready;
  assign w_finish    = ~flush & (r_state == ST_EXEC) & (r_cnt == '0);
  assign cdb_valid   = (r_state == ST_DONE);
  assign busy        = (r_state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_fire) w_next = ST_EXEC;
        ST_EXEC: if (r_cnt == '0) w_next = ST_DONE;
        ST_DONE: if (cdb_grant) w_next = w_fire ? ST_EXEC : ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Result registers update only on completion so a retired result lingers on the bus
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_tag    <= '0;
      r_src1   <= '0;
      r_src2   <= '0;
      cdb_tag  <= '0;
      cdb_data <= '0;
      cdb_err  <= 1'b0;
    end else begin
      if (flush) begin
        r_cnt <= '0;
      end else if (w_fire) begin
        r_op   <= issue_op;
        r_tag  <= issue_tag;
        r_src1 <= issue_src1;
        r_src2 <= issue_src2;
        r_cnt  <= lat_of(issue_op, LAT_ADD, LAT_MUL, LAT_DIV) - c_CNT_W'(1);
      end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end
      if (w_finish) begin
        cdb_tag  <= r_tag;
        cdb_data <= w_alu_data;
        cdb_err  <= w_alu_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uf_exec_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uf_exec_unit : scoreboard bench for uf_exec_unit               |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_uf_exec_unit;
  localparam int WIDTH = 16, TAG_W = 3, LAT_ADD = 1, LAT_MUL = 2, LAT_DIV = 4;

  logic             clock = 1'b0, reset_n = 1'b0, issue_valid = 1'b0, flush = 1'b0, cdb_grant = 1'b0;
  logic [3:0]       issue_op = '0;
  logic [TAG_W-1:0] issue_tag = '0;
  logic [WIDTH-1:0] issue_src1 = '0, issue_src2 = '0;
  logic             issue_ready, cdb_valid, cdb_err, busy;
  logic [TAG_W-1:0] cdb_tag;
  logic [WIDTH-1:0] cdb_data;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               due;
    bit               seen;
  } exp_t;
  exp_t q[$];

  uf_exec_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W), .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL),
                 .LAT_DIV(LAT_DIV)) dut (
    .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_tag(issue_tag), .issue_src1(issue_src1),
    .issue_src2(issue_src2), .flush(flush), .cdb_grant(cdb_grant), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_err(cdb_err), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: unsigned arithmetic reduced modulo 2^WIDTH
  function automatic exp_t model(input logic [3:0] op, input logic [TAG_W-1:0] tag,
                                 input logic [WIDTH-1:0] s1, input logic [WIDTH-1:0] s2,
                                 input int now);
    exp_t        e;
    longint      a = longint'(s1), b = longint'(s2), m = longint'(1) << WIDTH, r;
    int          lat;
    e.err = 1'b0;
    case (op)
      4'd0: begin r = (b + a) % m; lat = LAT_ADD; end
      4'd1: begin r = (b - a + m) % m; lat = LAT_ADD; end
      4'd4: begin r = (b * a) % m; lat = LAT_MUL; end
      4'd5: begin
        lat = LAT_DIV;
        if (a == 0) begin r = m - 1; e.err = 1'b1; end
        else r = b / a;
      end
      default: begin r = 0; e.err = 1'b1; lat = 1; end
    endcase
    e.data = WIDTH'(r);
    e.tag  = tag;
    e.due  = now + 1 + lat;
    e.seen = 1'b0;
    return e;
  endfunction

  // One cycle of stimulus; records expectation when the handshake fires
  task automatic drive_cycle(input bit v, input logic [3:0] op, input logic [TAG_W-1:0] tag,
                             input logic [WIDTH-1:0] s1, input logic [WIDTH-1:0] s2,
                             input bit g, input bit f, output bit fired, output bit rdy);
    @(posedge clock);
    #1;
    issue_valid = v; issue_op = op; issue_tag = tag; issue_src1 = s1; issue_src2 = s2;
    cdb_grant = g; flush = f;
    #1;
    rdy   = issue_ready;
    fired = reset_n && v && issue_ready;
    if (fired) q.push_back(model(op, tag, s1, s2, cyc));
  endtask

  task automatic idle_until_free(input bit g);
    bit fd, rd;
    int n = 0;
    do begin
      drive_cycle(0, 4'd0, '0, '0, '0, g, 0, fd, rd);
      n++;
    end while (busy && n < 20);
    chk("unit_free", 32'(busy), 0);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [TAG_W-1:0] tag,
                       input logic [WIDTH-1:0] s1, input logic [WIDTH-1:0] s2);
    bit fd = 0, rd;
    int n = 0;
    while (!fd && n < 20) begin
      drive_cycle(1, op, tag, s1, s2, 1, 0, fd, rd);
      n++;
    end
    chk("issue_accept", 32'(fd), 1);
    idle_until_free(1);
  endtask

  // Monitor: compares every presented result, retires it on grant
  always @(negedge clock) begin
    if (!reset_n) begin
      q.delete();
    end else begin
      if (cdb_valid) begin
        if (q.size() == 0) begin
          chk("spurious_cdb_valid", 32'(cdb_valid), 0);
        end else begin
          if (!q[0].seen) begin
            chk("latency", cyc, q[0].due);
            q[0].seen = 1'b1;
          end
          chk("cdb_data", 32'(cdb_data), 32'(q[0].data));
          chk("cdb_tag", 32'(cdb_tag), 32'(q[0].tag));
          chk("cdb_err", 32'(cdb_err), 32'(q[0].err));
          if (cdb_grant && !flush) void'(q.pop_front());
        end
      end else if (q.size() > 0 && !q[0].seen && cyc > q[0].due) begin
        chk("late_cdb_valid", 32'(cdb_valid), 1);
        void'(q.pop_front());
      end
      if (flush) q.delete();
    end
  end

  initial begin
    bit fd, rd;
    // Reset held with an op offered
    issue_valid = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_cdb_valid", 32'(cdb_valid), 0);
    chk("rst_cdb_tag", 32'(cdb_tag), 0);
    chk("rst_cdb_data", 32'(cdb_data), 0);
    chk("rst_cdb_err", 32'(cdb_err), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clock); #1;
    reset_n = 1'b1; issue_valid = 1'b0;
    #1 chk("rst_issue_ready", 32'(issue_ready), 1);

    do_op(4'b0000, 3'd2, 16'd3, 16'd5);
    do_op(4'b0001, 3'd3, 16'd5, 16'd3);
    do_op(4'b0100, 3'd4, 16'd300, 16'd300);
    do_op(4'b0101, 3'd5, 16'd7, 16'd100);
    do_op(4'b0101, 3'd6, 16'd0, 16'd9);
    do_op(4'b0011, 3'd7, 16'd1, 16'd2);

    // Back-pressure then back-to-back issue on the granting cycle
    drive_cycle(1, 4'b0100, 3'd1, 16'd12, 16'd11, 0, 0, fd, rd);
    chk("bp_issue", 32'(fd), 1);
    for (int i = 0; i < 7; i++) begin
      drive_cycle(0, 4'd0, '0, '0, '0, 0, 0, fd, rd);
      chk("bp_ready_low", 32'(rd), 0);
    end
    drive_cycle(1, 4'b0000, 3'd5, 16'd40, 16'd2, 1, 0, fd, rd);
    chk("b2b_fire", 32'(fd), 1);
    idle_until_free(1);

    // Flush during DIV execution, with an op offered
    drive_cycle(1, 4'b0101, 3'd3, 16'd3, 16'd99, 1, 0, fd, rd);
    drive_cycle(1, 4'b0000, 3'd4, 16'd1, 16'd1, 1, 1, fd, rd);
    chk("flush_no_accept", 32'(fd), 0);
    drive_cycle(0, 4'd0, '0, '0, '0, 1, 0, fd, rd);
    chk("flush_exec_busy", 32'(busy), 0);
    repeat (5) drive_cycle(0, 4'd0, '0, '0, '0, 1, 0, fd, rd);

    // Flush alongside grant while the result is held
    drive_cycle(1, 4'b0000, 3'd1, 16'd6, 16'd7, 0, 0, fd, rd);
    repeat (3) drive_cycle(0, 4'd0, '0, '0, '0, 0, 0, fd, rd);
    drive_cycle(1, 4'b0001, 3'd2, 16'd1, 16'd1, 1, 1, fd, rd);
    chk("flush_done_no_accept", 32'(fd), 0);
    drive_cycle(0, 4'd0, '0, '0, '0, 1, 0, fd, rd);
    chk("flush_done_busy", 32'(busy), 0);
    chk("flush_done_valid", 32'(cdb_valid), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      logic [WIDTH-1:0] s1;
      case ($urandom_range(0, 4))
        0: op = 4'b0000;
        1: op = 4'b0001;
        2: op = 4'b0100;
        3: op = 4'b0101;
        default: op = 4'($urandom);
      endcase
      s1 = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
      drive_cycle($urandom_range(0, 9) < 7, op, TAG_W'($urandom), s1, WIDTH'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0, fd, rd);
    end
    idle_until_free(1);
    repeat (3) drive_cycle(0, 4'd0, '0, '0, '0, 1, 0, fd, rd);
    chk("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
